// File: rtl/bit_deposit64_pkg.sv
// Shared types and widths for the serial bit depositor.
package bit_deposit64_pkg;
    localparam int WORD_W = 64;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // A requested count of zero means a full word.
    function automatic logic [CNT_W-1:0] fill_len(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? CNT_W'(WORD_W) : cnt;
    endfunction
endpackage

// File: rtl/bit_deposit64_decode6to64.sv
// One-hot write-enable decode of a 6-bit bit index, gated by the accept strobe.
module bit_deposit64_decode6to64
    import bit_deposit64_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    input  logic              en,
    output logic [WORD_W-1:0] mask
);
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_dec
            assign mask[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/bit_deposit64.sv
// Serial-to-parallel bit depositor: writes streamed bits into a 64-bit word at an
// auto-incrementing index, then holds the word until the consumer takes it.
module bit_deposit64
    import bit_deposit64_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  start_idx,
    input  logic [CNT_W-1:0]  count,
    input  logic              clear,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy
);
    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [WORD_W-1:0]  word_reg;
    logic               bit_ready_reg;
    logic               word_valid_reg;
    logic               busy_reg;
    logic               accept;
    logic [WORD_W-1:0]  mask;

    assign accept = (state_reg == ST_FILL) && bit_valid && bit_ready_reg;

    bit_deposit64_decode6to64 u_dec (
        .idx  (idx_reg),
        .en   (accept),
        .mask (mask)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            remaining_reg  <= '0;
            word_reg       <= '0;
            bit_ready_reg  <= 1'b0;
            word_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        idx_reg       <= start_idx;
                        remaining_reg <= fill_len(count);
                        if (clear) begin
                            word_reg <= '0;
                        end
                        state_reg     <= ST_FILL;
                        bit_ready_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        word_reg      <= (word_reg & ~mask) | ({WORD_W{bit_in}} & mask);
                        idx_reg       <= idx_reg + IDX_W'(1);
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        // Last bit: the finished word is presented on the very next cycle.
                        if (remaining_reg == CNT_W'(1)) begin
                            state_reg      <= ST_HOLD;
                            bit_ready_reg  <= 1'b0;
                            word_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (word_ready) begin
                        state_reg      <= ST_IDLE;
                        word_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    bit_ready_reg  <= 1'b0;
                    word_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign bit_ready  = bit_ready_reg;
    assign word_out   = word_reg;
    assign word_valid = word_valid_reg;
    assign busy       = busy_reg;
endmodule

// File: tb/tb_bit_deposit64.sv
// Directed and randomized checks of bit_deposit64 against a per-bit word model.
module tb_bit_deposit64;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  start_idx = '0;
    logic [6:0]  count = '0;
    logic        clear = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_ready;
    logic [63:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;
    logic [63:0] model_word = '0;

    bit_deposit64 dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .start_idx  (start_idx),
        .count      (count),
        .clear      (clear),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_word"}, word_out, 64'h0);
        chk({tag, "_ready"}, {63'h0, bit_ready}, 64'h0);
        chk({tag, "_valid"}, {63'h0, word_valid}, 64'h0);
        chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
    endtask

    // One complete fill: start, stream bits (optionally with gaps and stray starts),
    // hold the finished word for hold_cycles of backpressure, then hand it off.
    task automatic run_fill(input logic [5:0] sidx, input logic [6:0] cnt, input logic clr,
                            input logic [63:0] data, input bit gaps, input int hold_cycles,
                            input string tag);
        int n;
        int k;
        int cyc;
        int early;
        int hold_bad;
        logic [63:0] expv;
        n = (cnt == 7'd0) ? 64 : int'(cnt);
        expv = clr ? 64'h0 : model_word;
        for (int i = 0; i < n; i++) expv[(int'(sidx) + i) % 64] = data[i];

        start = 1'b1; start_idx = sidx; count = cnt; clear = clr;
        tick();
        start = 1'b0;
        start_idx = 6'($urandom); count = 7'($urandom); clear = 1'($urandom);
        chk({tag, "_ready_after_start"}, {63'h0, bit_ready}, 64'h1);
        chk({tag, "_busy_after_start"}, {63'h0, busy}, 64'h1);

        k = 0; cyc = 0; early = 0;
        while (k < n && cyc < 1000) begin
            if (gaps) start = 1'($urandom);
            if (gaps && $urandom_range(0, 2) == 0) begin
                bit_valid = 1'b0;
                bit_in = 1'($urandom);
            end else begin
                bit_valid = 1'b1;
                bit_in = data[k];
                k++;
            end
            tick();
            cyc++;
            if (k < n && word_valid) early++;
        end
        bit_valid = 1'b0; start = 1'b0;
        chk({tag, "_early_valid"}, 64'(early), 64'h0);
        if (!gaps) chk({tag, "_cycles"}, 64'(cyc), 64'(n));
        chk({tag, "_word_valid"}, {63'h0, word_valid}, 64'h1);
        chk({tag, "_word"}, word_out, expv);
        chk({tag, "_ready_in_hold"}, {63'h0, bit_ready}, 64'h0);

        hold_bad = 0;
        for (int h = 0; h < hold_cycles; h++) begin
            bit_valid = 1'($urandom); bit_in = 1'($urandom); start = 1'($urandom);
            tick();
            if (word_out !== expv || word_valid !== 1'b1 || bit_ready !== 1'b0 || busy !== 1'b1)
                hold_bad++;
        end
        bit_valid = 1'b0; start = 1'b0;
        chk({tag, "_hold_stable"}, 64'(hold_bad), 64'h0);

        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk({tag, "_valid_after_handoff"}, {63'h0, word_valid}, 64'h0);
        chk({tag, "_busy_after_handoff"}, {63'h0, busy}, 64'h0);
        chk({tag, "_word_after_handoff"}, word_out, expv);
        $display("fill %s: sidx=%0d cnt=%0d clr=%0d word=%h", tag, sidx, cnt, clr, word_out);
        model_word = expv;
    endtask

    initial begin
        #2;
        check_reset_outputs("reset");
        #10 reset_n = 1'b1;
        tick();
        check_reset_outputs("post_reset_idle");

        run_fill(6'd0, 7'd0, 1'b1, 64'hA5A5_0000_FFFF_1234, 1'b0, 0, "full");
        chk("full_const", word_out, 64'hA5A5_0000_FFFF_1234);

        run_fill(6'd62, 7'd4, 1'b1, 64'hF, 1'b0, 0, "wrap");
        chk("wrap_const", word_out, 64'hC000_0000_0000_0003);

        run_fill(6'd8, 7'd8, 1'b0, 64'h0, 1'b0, 0, "merge");
        chk("merge_const", word_out, 64'hC000_0000_0000_0003);

        run_fill(6'd40, 7'd30, 1'b0, {$urandom, $urandom}, 1'b1, 10, "gaps");

        // Stray bits and word_ready while idle must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = 1'($urandom); word_ready = 1'($urandom);
            tick();
        end
        bit_valid = 1'b0; word_ready = 1'b0;
        chk("idle_word", word_out, model_word);
        chk("idle_valid", {63'h0, word_valid}, 64'h0);
        chk("idle_busy", {63'h0, busy}, 64'h0);
        run_fill(6'd3, 7'd5, 1'b0, {$urandom, $urandom}, 1'b0, 0, "after_idle");

        for (int r = 0; r < 12; r++) begin
            run_fill(6'($urandom), 7'($urandom_range(0, 64)), 1'($urandom),
                     {$urandom, $urandom}, 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        // Abort a full fill after 20 bits with an asynchronous reset.
        start = 1'b1; start_idx = 6'd17; count = 7'd0; clear = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'b1; bit_in = 1'($urandom);
            tick();
        end
        bit_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        check_reset_outputs("reset_next_cycle");
        reset_n = 1'b1;
        model_word = 64'h0;
        tick();
        run_fill(6'd50, 7'd20, 1'b0, {$urandom, $urandom}, 1'b0, 2, "post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
